// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and op-class helpers for the multiply/divide unit.
// Optional MULDIV_MACC_EN turns MADD/MADDU/MSUB/MSUBU into multiply-class ops.
package muldiv_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic is_mul_op(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MULDIV_MACC_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the E stage and the multiply/divide unit.
interface muldiv_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, output op, output a, output b,
                  input busy, input hi, input lo);
  modport slave  (input start, input op, input a, input b,
                  output busy, output hi, output lo);
endinterface

// File: rtl/muldiv_arith.sv
// Combinational result generator: next {hi,lo} from latched op/operands and current HI/LO.
// MULDIV_MACC_EN adds multiply-accumulate/subtract on the current HI/LO.
module muldiv_arith
  import muldiv_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] hi_nxt,
  output logic [31:0] lo_nxt
);

  logic [63:0] prod_u, prod_s, acc;
  logic [31:0] abs_a, abs_b, mag_q, mag_r, sq, sr;
  logic [31:0] safe_b, uq, ur;
  logic        b_zero;

  assign prod_u = {32'b0, a} * {32'b0, b};
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign acc    = {hi, lo};
  assign b_zero = (b == 32'b0);

  // Signed divide via magnitudes; 0x80000000 / -1 naturally yields lo=0x80000000, hi=0.
  assign abs_a  = a[31] ? (32'b0 - a) : a;
  assign abs_b  = b[31] ? (32'b0 - b) : b;
  assign mag_q  = abs_a / (b_zero ? 32'd1 : abs_b);
  assign mag_r  = abs_a % (b_zero ? 32'd1 : abs_b);
  assign sq     = (a[31] ^ b[31]) ? (32'b0 - mag_q) : mag_q;
  assign sr     = a[31] ? (32'b0 - mag_r) : mag_r;

  assign safe_b = b_zero ? 32'd1 : b;
  assign uq     = a / safe_b;
  assign ur     = a % safe_b;

  always_comb begin
    {hi_nxt, lo_nxt} = acc;
    case (op)
      OP_MULT:  {hi_nxt, lo_nxt} = prod_s;
      OP_MULTU: {hi_nxt, lo_nxt} = prod_u;
      OP_DIV: begin
        hi_nxt = b_zero ? a : sr;
        lo_nxt = b_zero ? 32'hFFFF_FFFF : sq;
      end
      OP_DIVU: begin
        hi_nxt = b_zero ? a : ur;
        lo_nxt = b_zero ? 32'hFFFF_FFFF : uq;
      end
`ifdef MULDIV_MACC_EN
      OP_MADD:  {hi_nxt, lo_nxt} = acc + prod_s;
      OP_MADDU: {hi_nxt, lo_nxt} = acc + prod_u;
      OP_MSUB:  {hi_nxt, lo_nxt} = acc - prod_s;
      OP_MSUBU: {hi_nxt, lo_nxt} = acc - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide controller with HI/LO registers and a fixed-latency busy window.
// MULDIV_MACC_EN enables MADD/MADDU/MSUB/MSUBU (MUL_CYCLES latency).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic    clk,
  input  logic    reset_n,
  muldiv_if.slave bus
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      res_hi, res_lo;
  logic             accept;

  muldiv_arith u_arith (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .hi_nxt (res_hi),
    .lo_nxt (res_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_mul_op(bus.op)) begin
            state_d = ST_RUN;
            cnt_d   = MUL_LOAD;
            accept  = 1'b1;
          end else if (is_div_op(bus.op)) begin
            state_d = ST_RUN;
            cnt_d   = DIV_LOAD;
            accept  = 1'b1;
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.a;
          end
        end
      end
      ST_RUN: begin
        // start is not looked at here, so a stray request leaves the latches untouched
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= bus.op;
      a_q  <= bus.a;
      b_q  <= bus.b;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit; expectations follow MULDIV_MACC_EN when it is defined.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_fail;
  logic [31:0] m_hi, m_lo;

  muldiv_if bus ();

  muldiv_unit #(
    .MUL_CYCLES (5),
    .DIV_CYCLES (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Counts remaining busy cycles, checking HI/LO hold, then checks the committed result.
  task automatic drain(input string tag, input int exp_n,
                       input logic [31:0] eh, input logic [31:0] el);
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      check({tag, " hold hi"}, bus.hi, m_hi);
      check({tag, " hold lo"}, bus.lo, m_lo);
      n++;
      tick();
    end
    check({tag, " busy cycles"}, 32'(n), 32'(exp_n));
    check({tag, " hi"}, bus.hi, eh);
    check({tag, " lo"}, bus.lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    m_hi      = '0;
    m_lo      = '0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    reset_n = 1'b1;
    tick();

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    drain("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE);

    // Back-to-back: issued in the first cycle busy is seen low
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    drain("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    drain("div neg", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(OP_DIVU, 32'd7, 32'd0);
    drain("divu by0", 10, 32'd7, 32'hFFFF_FFFF);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    drain("div ovf", 10, 32'd0, 32'h8000_0000);

    issue(OP_DIVU, 32'd100, 32'd7);
    drain("divu", 10, 32'd2, 32'd14);

    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    drain("div negb", 10, 32'd1, 32'hFFFF_FFFD);

    // Stray start mid-run must not disturb latched operands; one busy cycle is spent here
    issue(OP_MULTU, 32'd3, 32'd5);
    issue(OP_DIVU, 32'd7, 32'd7);
    drain("stray start", 4, 32'd0, 32'd15);
    check("stray no restart", {31'b0, bus.busy}, 32'd0);

    issue(OP_MTHI, 32'h0000_1234, 32'd0);
    check("mthi busy", {31'b0, bus.busy}, 32'd0);
    check("mthi hi", bus.hi, 32'h0000_1234);
    check("mthi lo kept", bus.lo, 32'd15);
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
    check("mtlo busy", {31'b0, bus.busy}, 32'd0);
    check("mtlo lo", bus.lo, 32'hFFFF_FFFF);
    check("mthi zero", bus.hi, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'hFFFF_FFFF;

`ifdef MULDIV_MACC_EN
    issue(OP_MADDU, 32'd1, 32'd1);
    drain("maddu", 5, 32'd1, 32'd0);
    issue(OP_MSUB, 32'd2, 32'd3);
    drain("msub", 5, 32'd0, 32'hFFFF_FFFA);
`else
    issue(OP_MADDU, 32'd1, 32'd1);
    drain("maddu noop", 0, 32'd0, 32'hFFFF_FFFF);
    issue(OP_MSUB, 32'd2, 32'd3);
    drain("msub noop", 0, 32'd0, 32'hFFFF_FFFF);
`endif

    issue(4'd12, 32'h5555_5555, 32'd9);
    drain("op12 noop", 0, m_hi, m_lo);

    // Reset during RUN: MULT accepted, stray start in cycle 2, reset in cycle 3
    issue(OP_MULT, 32'd3, 32'd5);
    check("pre-reset busy", {31'b0, bus.busy}, 32'd1);
    issue(OP_DIVU, 32'd100, 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst busy", {31'b0, bus.busy}, 32'd0);
    check("midrst hi", bus.hi, 32'd0);
    check("midrst lo", bus.lo, 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("postrst busy", {31'b0, bus.busy}, 32'd0);
    end
    check("postrst hi", bus.hi, 32'd0);
    check("postrst lo", bus.lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
